// File: rtl/zion_bc_skid_buf.sv
// rtl/zion_bc_skid_buf.sv - two-entry registered skid buffer (main + skid register slice)
//
// Purpose:
//   Full-throughput register slice between an upstream valid/ready producer
//   and a downstream consumer. Every output (oVld, oRdy, oCnt, oDat) comes
//   straight from a flop, so no input reaches an output combinationally.
//   The main register always drives oDat. The skid register catches the one
//   word that can arrive in the same cycle the downstream side stalls.
//
// Ports:
//   clk     in   1          sole clock, rising edge
//   rst     in   1          synchronous active-high reset
//   iFlush  in   1          synchronous clear of buffered contents
//   iVld    in   1          upstream valid
//   oRdy    out  1          ready to upstream (registered)
//   iDat    in   WIDTH_DAT  upstream data
//   oVld    out  1          valid to downstream (registered)
//   iRdy    in   1          downstream ready
//   oDat    out  WIDTH_DAT  downstream data (main register)
//   oCnt    out  2          occupancy 0..2, equal to the encoded state

module zion_bc_skid_buf #(
  parameter int                   WIDTH_DAT = 32,
  parameter logic [WIDTH_DAT-1:0] INI_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iFlush,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [WIDTH_DAT-1:0] iDat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [WIDTH_DAT-1:0] oDat,
  output logic [1:0]           oCnt
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH_DAT-1:0] main_q,  main_d;
  logic [WIDTH_DAT-1:0] skid_q,  skid_d;
  logic                 vld_q,   vld_d;
  logic                 rdy_q,   rdy_d;

  // Next-state and data-path steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (iVld) begin
          main_d  = iDat;
          state_d = ST_ONE;
        end
      end

      ST_ONE: begin
        unique case ({iVld, iRdy})
          2'b11: main_d = iDat;        // pass-through: one in, one out
          2'b10: begin                 // downstream stalls: park new word in skid
            skid_d  = iDat;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;   // drain the only word
          default: ;                   // hold
        endcase
      end

      ST_FULL: begin
        // oRdy is low here, so upstream traffic is ignored entirely.
        if (iRdy) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end

      default: state_d = ST_EMPTY;
    endcase

    // Flush empties the slice but leaves the data registers untouched, so
    // oDat keeps showing the last word while oVld is low.
    if (iFlush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // Handshake outputs are precomputed from the next state so they can be
    // registered alongside it.
    vld_d = (state_d != ST_EMPTY);
    rdy_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= INI_DATA;
      skid_q  <= INI_DATA;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign oVld = vld_q;
  assign oRdy = rdy_q;
  assign oDat = main_q;
  assign oCnt = state_q;

endmodule

// File: tb/tb_zion_bc_skid_buf.sv
// tb/tb_zion_bc_skid_buf.sv - directed and scoreboard bench for zion_bc_skid_buf

module tb_zion_bc_skid_buf;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         iFlush;
  logic         iVld;
  logic         oRdy;
  logic [W-1:0] iDat;
  logic         oVld;
  logic         iRdy;
  logic [W-1:0] oDat;
  logic [1:0]   oCnt;

  int n_checks = 0;
  int n_errors = 0;

  zion_bc_skid_buf #(.WIDTH_DAT(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .iFlush (iFlush),
    .iVld   (iVld),
    .oRdy   (oRdy),
    .iDat   (iDat),
    .oVld   (oVld),
    .iRdy   (iRdy),
    .oDat   (oDat),
    .oCnt   (oCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] rd;

  initial begin
    rst = 1'b1; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = '0;
    step();
    rst = 1'b0;

    // Reset then idle
    chk("rst_vld", oVld, 0);
    chk("rst_rdy", oRdy, 1);
    chk("rst_cnt", oCnt, 0);
    chk("rst_dat", oDat, 0);

    // Single word held under backpressure, then drained
    iVld = 1; iDat = 32'hA5A5_0001; iRdy = 0;
    step();
    iVld = 0;
    chk("sw_vld", oVld, 1);
    chk("sw_dat", oDat, 32'hA5A5_0001);
    chk("sw_cnt", oCnt, 1);
    step();
    chk("sw_hold_vld", oVld, 1);
    chk("sw_hold_dat", oDat, 32'hA5A5_0001);
    iRdy = 1;
    step();
    iRdy = 0;
    chk("sw_drain_cnt", oCnt, 0);
    chk("sw_drain_vld", oVld, 0);
    chk("sw_drain_dat_hold", oDat, 32'hA5A5_0001);

    // Backpressure fill, word offered while FULL is ignored
    iVld = 1; iDat = 32'h11;
    step();
    chk("bp1_cnt", oCnt, 1);
    iDat = 32'h22;
    step();
    chk("bp2_cnt", oCnt, 2);
    chk("bp2_rdy", oRdy, 0);
    chk("bp2_dat", oDat, 32'h11);
    iDat = 32'h33;
    step();
    chk("bp3_cnt", oCnt, 2);
    chk("bp3_dat", oDat, 32'h11);
    iVld = 0; iRdy = 1;
    step();
    chk("bp4_cnt", oCnt, 1);
    chk("bp4_dat", oDat, 32'h22);
    chk("bp4_rdy", oRdy, 1);
    step();
    chk("bp5_cnt", oCnt, 0);
    chk("bp5_vld", oVld, 0);
    iRdy = 0;

    // Streaming at full throughput
    iVld = 1; iRdy = 1;
    for (int i = 1; i <= 8; i++) begin
      iDat = W'(i);
      step();
      chk("str_dat", oDat, W'(i));
      chk("str_cnt", oCnt, 1);
      chk("str_rdy", oRdy, 1);
      chk("str_vld", oVld, 1);
    end
    iVld = 0;
    step();
    chk("str_end_cnt", oCnt, 0);
    iRdy = 0;

    // Flush while FULL
    iVld = 1; iDat = 32'h44;
    step();
    iDat = 32'h55;
    step();
    chk("fl_pre_cnt", oCnt, 2);
    iVld = 0; iFlush = 1; iRdy = 1;
    step();
    iFlush = 0;
    chk("fl_vld", oVld, 0);
    chk("fl_cnt", oCnt, 0);
    chk("fl_rdy", oRdy, 1);
    chk("fl_dat_hold", oDat, 32'h44);
    step();
    chk("fl_no55_vld", oVld, 0);
    chk("fl_no55_dat", oDat, 32'h44);
    iRdy = 0;

    // Reset mid-operation while FULL
    iVld = 1; iDat = 32'h66;
    step();
    iDat = 32'h77;
    step();
    chk("rm_pre_cnt", oCnt, 2);
    iVld = 0; rst = 1;
    step();
    rst = 0;
    chk("rm_cnt", oCnt, 0);
    chk("rm_vld", oVld, 0);
    chk("rm_rdy", oRdy, 1);
    chk("rm_dat", oDat, 0);

    // Random traffic against a queue scoreboard
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      iVld   = 1'($urandom_range(0, 1));
      iRdy   = 1'($urandom_range(0, 1));
      iDat   = $urandom;
      iFlush = ($urandom_range(0, 39) == 0);
      if (iFlush) begin
        q.delete();
      end else begin
        logic acc;
        acc = iVld && (q.size() < 2);
        if (q.size() > 0 && iRdy) begin
          rd = q.pop_front();
          chk("rnd_out_dat", oDat, rd);
        end
        if (acc) q.push_back(iDat);
      end
      step();
      chk("rnd_cnt", oCnt, W'(q.size()));
      chk("rnd_vld", oVld, W'(q.size() > 0));
      chk("rnd_rdy", oRdy, W'(q.size() < 2));
      if (q.size() > 0) chk("rnd_head", oDat, q[0]);
    end
    iVld = 0; iRdy = 0; iFlush = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zion_bc_skid_buf.md
ZION_BC_SKID_BUF -- requirements
Module: zion_bc_skid_buf

Interface
REQ-001 The block SHALL have parameter WIDTH_DAT, default 32, data path width in bits.
REQ-002 The block SHALL have parameter INI_DATA, default 0, reset value of both data registers.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port iFlush  input  1  synchronous clear of buffered contents.
REQ-006 Port iVld  input  1  upstream data valid.
REQ-007 Port oRdy  output  1  ready to upstream.
REQ-008 Port iDat  input  WIDTH_DAT  upstream data.
REQ-009 Port oVld  output  1  valid to downstream (feeds iEn of the downstream enable register).
REQ-010 Port iRdy  input  1  downstream ready.
REQ-011 Port oDat  output  WIDTH_DAT  downstream data.
REQ-012 Port oCnt  output  2  current occupancy, 0..2.

Function
REQ-013 The block SHALL be a two-entry register slice (main register plus skid register) with three states: EMPTY (cnt 0), ONE (cnt 1), FULL (cnt 2).
REQ-014 Upstream transfer SHALL occur on a cycle with iVld=1 and oRdy=1; downstream transfer on a cycle with oVld=1 and iRdy=1.
REQ-015 oVld, oRdy, oCnt and oDat SHALL be driven directly from registers; no combinational path from any input to any output.
REQ-016 oVld SHALL be 1 in ONE and FULL and 0 in EMPTY; oRdy SHALL be 1 in EMPTY and ONE and 0 in FULL.
REQ-017 oDat SHALL always equal the main register; with oVld=0 it SHALL hold its last value.
REQ-018 EMPTY: iVld=1 -> main<=iDat, next ONE; else stay EMPTY.
REQ-019 ONE: iVld=1,iRdy=1 -> main<=iDat, stay ONE; iVld=1,iRdy=0 -> skid<=iDat, next FULL; iVld=0,iRdy=1 -> next EMPTY; iVld=0,iRdy=0 -> hold.
REQ-020 FULL: iRdy=1 -> main<=skid, next ONE; iRdy=0 -> hold; iVld/iDat SHALL be ignored in FULL.
REQ-021 Data registers SHALL load only on the conditions in REQ-018..REQ-020 and hold otherwise.
REQ-022 Latency SHALL be 1 cycle: data accepted at edge N is on oDat with oVld=1 after edge N when the block was EMPTY or draining in ONE.
REQ-023 Sustained iVld=1 and iRdy=1 SHALL give one transfer per cycle (full throughput) with no bubbles.
REQ-024 Data SHALL leave in acceptance order; no word SHALL be dropped or duplicated except by flush or reset.
REQ-025 iFlush=1 SHALL force next state EMPTY regardless of handshakes; a word accepted upstream or delivered downstream in the flush cycle is discarded/consumed; data registers hold their values.
REQ-026 Priority SHALL be rst > iFlush > handshake.
REQ-027 oCnt SHALL equal the encoded state (EMPTY=0, ONE=1, FULL=2); value 3 SHALL never occur.

Reset
REQ-028 On a rising edge with rst=1 the block SHALL enter EMPTY: oVld=0, oRdy=1, oCnt=0, main and skid = INI_DATA, oDat=INI_DATA.
REQ-029 Reset asserted mid-operation (ONE or FULL) SHALL discard all buffered words at that edge; no output changes before the edge.
REQ-030 Before the first reset edge output values are undefined; the bench SHALL not check them.

Verification
REQ-031 Reset then idle: rst=1 one edge, iVld=0 -> oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA (0).
REQ-032 Single word: EMPTY, iVld=1 iDat=0xA5A5_0001, iRdy=0 -> next cycle oVld=1, oDat=0xA5A5_0001, oCnt=1; oVld held until iRdy=1, then oCnt=0.
REQ-033 Backpressure fill: iRdy=0, send 0x11 then 0x22 -> oCnt=2, oRdy=0, oDat=0x11; 0x33 offered while FULL is ignored; iRdy=1 two cycles -> outputs 0x11 then 0x22, oCnt 2->1->0.
REQ-034 Streaming: iVld=iRdy=1 for 8 cycles with iDat=1..8 -> oDat 1..8 on consecutive cycles, oCnt=1 throughout, oRdy=1.
REQ-035 Flush in FULL: buffer 0x44,0x55, assert iFlush with iRdy=1 -> next cycle oVld=0, oCnt=0, oRdy=1; 0x55 never appears.
REQ-036 Random: iVld, iRdy, iDat random 1000 cycles vs scoreboard queue -> order and content match, oCnt equals model occupancy every cycle.
